// File: rtl/i_exec_pipe_if.sv
// Opcode/destination encodings and the valid/ready bundle for the I-type execute stage.
// The upstream/downstream side uses the master modport; the execute stage uses slave.
`ifndef I_EXEC_PIPE_DEFS
`define I_EXEC_PIPE_DEFS
`define OP_BEQ          6'h04
`define OP_BNE          6'h05
`define OP_BLEZ         6'h06
`define OP_BGTZ         6'h07
`define OP_ADDI         6'h08
`define OP_ADDIU        6'h09
`define OP_SLTI         6'h0a
`define OP_SLTIU        6'h0b
`define OP_ANDI         6'h0c
`define OP_ORI          6'h0d
`define OP_XORI         6'h0e
`define OP_LUI          6'h0f
`define OP_LW           6'h23
`define OP_SW           6'h2b
`define DST_TYPE_WIDTH  3
`define DST_NONE        3'd0
`define DST_RT          3'd1
`define DST_PC          3'd2
`define DST_MEM_L       3'd3
`define DST_MEM_S       3'd4
`endif

interface i_exec_pipe_if #(
    parameter int XLEN = 32
);
    logic                        in_valid;
    logic                        in_ready;
    logic [5:0]                  op;
    logic [XLEN-1:0]             rs_data;
    logic [XLEN-1:0]             rt_data;
    logic [15:0]                 imm16;
    logic [XLEN-1:0]             pc;
    logic                        out_valid;
    logic                        out_ready;
    logic [XLEN-1:0]             res;
    logic [`DST_TYPE_WIDTH-1:0]  dst_type;
    logic [XLEN-1:0]             br_target;
    logic                        exc;
    logic [1:0]                  exc_code;

    modport master (
        output in_valid, op, rs_data, rt_data, imm16, pc, out_ready,
        input  in_ready, out_valid, res, dst_type, br_target, exc, exc_code
    );

    modport slave (
        input  in_valid, op, rs_data, rt_data, imm16, pc, out_ready,
        output in_ready, out_valid, res, dst_type, br_target, exc, exc_code
    );
endinterface

// File: rtl/i_exec_pipe.sv
// I-type execute stage with valid/ready on both sides and a configurable latency (1..4).
// Operands are captured on accept; results are derived from the captured copies and held until consumed.
module i_exec_pipe #(
    parameter int XLEN       = 32,
    parameter int LATENCY    = 1,
    parameter int ZEXT_LOGIC = 1,
    parameter int TRAP_OVF   = 1
) (
    input  logic         clk,
    input  logic         clrn,
    i_exec_pipe_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic       SINGLE   = (LATENCY <= 1);
    localparam logic [1:0] CNT_INIT = (LATENCY > 1) ? 2'(LATENCY - 2) : 2'd0;

    state_t     state;
    state_t     state_n;
    logic [1:0] cnt;
    logic [1:0] cnt_n;
    logic       in_ready;
    logic       accept;
    logic       done;

    logic [5:0]      op_q;
    logic [XLEN-1:0] rs_q;
    logic [XLEN-1:0] rt_q;
    logic [XLEN-1:0] pc_q;
    logic [15:0]     imm_q;

    logic [XLEN-1:0]            imm32;
    logic [XLEN-1:0]            imm_l;
    logic [XLEN-1:0]            sum;
    logic [XLEN-1:0]            target;
    logic                       ovf;
    logic [XLEN-1:0]            calc_res;
    logic [`DST_TYPE_WIDTH-1:0] calc_dst;
    logic                       calc_exc;
    logic [1:0]                 calc_code;

    assign done     = (state == DONE);
    assign in_ready = (state == IDLE) || (done && bus.out_ready);
    assign accept   = bus.in_valid && in_ready;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state <= IDLE;
            cnt   <= 2'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // A consume with a simultaneous accept restarts the pipe without an idle bubble.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_n = SINGLE ? DONE : BUSY;
                    cnt_n   = CNT_INIT;
                end
            end
            BUSY: begin
                if (cnt == 2'd0) begin
                    state_n = DONE;
                end else begin
                    cnt_n = cnt - 2'd1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    if (bus.in_valid) begin
                        state_n = SINGLE ? DONE : BUSY;
                        cnt_n   = CNT_INIT;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            op_q  <= 6'd0;
            rs_q  <= '0;
            rt_q  <= '0;
            pc_q  <= '0;
            imm_q <= 16'd0;
        end else if (accept) begin
            op_q  <= bus.op;
            rs_q  <= bus.rs_data;
            rt_q  <= bus.rt_data;
            pc_q  <= bus.pc;
            imm_q <= bus.imm16;
        end
    end

    assign imm32  = {{(XLEN-16){imm_q[15]}}, imm_q};
    assign imm_l  = (ZEXT_LOGIC != 0) ? {{(XLEN-16){1'b0}}, imm_q} : imm32;
    assign sum    = rs_q + imm32;
    assign target = pc_q + {{(XLEN-3){1'b0}}, 3'd4} + {imm32[XLEN-3:0], 2'b00};
    assign ovf    = (rs_q[XLEN-1] == imm32[XLEN-1]) && (sum[XLEN-1] != rs_q[XLEN-1]);

    // Exceptions keep res (the address for LW/SW) but redirect the destination to nowhere.
    always_comb begin
        calc_res  = '0;
        calc_dst  = `DST_NONE;
        calc_exc  = 1'b0;
        calc_code = 2'd0;
        case (op_q)
            `OP_ADDI: begin
                calc_res = sum;
                calc_dst = `DST_RT;
                if ((TRAP_OVF != 0) && ovf) begin
                    calc_dst  = `DST_NONE;
                    calc_exc  = 1'b1;
                    calc_code = 2'd1;
                end
            end
            `OP_ADDIU: begin
                calc_res = sum;
                calc_dst = `DST_RT;
            end
            `OP_SLTI: begin
                calc_res = {{(XLEN-1){1'b0}}, ($signed(rs_q) < $signed(imm32))};
                calc_dst = `DST_RT;
            end
            `OP_SLTIU: begin
                calc_res = {{(XLEN-1){1'b0}}, (rs_q < imm32)};
                calc_dst = `DST_RT;
            end
            `OP_ANDI: begin
                calc_res = rs_q & imm_l;
                calc_dst = `DST_RT;
            end
            `OP_ORI: begin
                calc_res = rs_q | imm_l;
                calc_dst = `DST_RT;
            end
            `OP_XORI: begin
                calc_res = rs_q ^ imm_l;
                calc_dst = `DST_RT;
            end
            `OP_LUI: begin
                calc_res = XLEN'({imm_q, 16'h0000});
                calc_dst = `DST_RT;
            end
            `OP_BEQ: begin
                calc_res = {{(XLEN-1){1'b0}}, (rs_q == rt_q)};
                calc_dst = `DST_PC;
            end
            `OP_BNE: begin
                calc_res = {{(XLEN-1){1'b0}}, (rs_q != rt_q)};
                calc_dst = `DST_PC;
            end
            `OP_BLEZ: begin
                calc_res = {{(XLEN-1){1'b0}}, (rs_q[XLEN-1] || (rs_q == '0))};
                calc_dst = `DST_PC;
            end
            `OP_BGTZ: begin
                calc_res = {{(XLEN-1){1'b0}}, (!rs_q[XLEN-1] && (rs_q != '0))};
                calc_dst = `DST_PC;
            end
            `OP_LW: begin
                calc_res = sum;
                calc_dst = `DST_MEM_L;
                if (sum[1:0] != 2'b00) begin
                    calc_dst  = `DST_NONE;
                    calc_exc  = 1'b1;
                    calc_code = 2'd2;
                end
            end
            `OP_SW: begin
                calc_res = sum;
                calc_dst = `DST_MEM_S;
                if (sum[1:0] != 2'b00) begin
                    calc_dst  = `DST_NONE;
                    calc_exc  = 1'b1;
                    calc_code = 2'd3;
                end
            end
            default: begin
                calc_res  = '0;
                calc_dst  = `DST_NONE;
                calc_exc  = 1'b0;
                calc_code = 2'd0;
            end
        endcase
    end

    // Outputs read as zero / DST_NONE whenever no result is being offered.
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = done;
    assign bus.res       = done ? calc_res  : '0;
    assign bus.dst_type  = done ? calc_dst  : `DST_NONE;
    assign bus.br_target = done ? target    : '0;
    assign bus.exc       = done ? calc_exc  : 1'b0;
    assign bus.exc_code  = done ? calc_code : 2'd0;

endmodule
